seven_segment_scanner: RTL and testbench

//  Time-multiplexes NUM_DIGITS hex digits onto one shared active-low cathode bus (seg_n/dp_n) with
//  per-digit active-low anodes. Sits between user logic and the board 7-seg pins.

---
 rtl/seven_segment_pkg.sv | 31 +++
 rtl/seven_segment_scanner_seg7_hex_decode.sv | 33 +++
 rtl/seven_segment_scanner.sv | 186 ++++++++++++++++++
 tb/tb_seven_segment_scanner.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// Shared constants and types for the seven_segment_scanner display block.
// Glyphs are active-low, segment A..G on bits [0]..[6].
package seven_segment_pkg;

    localparam logic [6:0] SEG_BLANK_N = 7'h7F;

    localparam logic [6:0] GLYPH_0_N = 7'h40;
    localparam logic [6:0] GLYPH_1_N = 7'h79;
    localparam logic [6:0] GLYPH_2_N = 7'h24;
    localparam logic [6:0] GLYPH_3_N = 7'h30;
    localparam logic [6:0] GLYPH_4_N = 7'h19;
    localparam logic [6:0] GLYPH_5_N = 7'h12;
    localparam logic [6:0] GLYPH_6_N = 7'h02;
    localparam logic [6:0] GLYPH_7_N = 7'h78;
    localparam logic [6:0] GLYPH_8_N = 7'h00;
    localparam logic [6:0] GLYPH_9_N = 7'h10;
    localparam logic [6:0] GLYPH_A_N = 7'h08;
    localparam logic [6:0] GLYPH_B_N = 7'h03;
    localparam logic [6:0] GLYPH_C_N = 7'h46;
    localparam logic [6:0] GLYPH_D_N = 7'h21;
    localparam logic [6:0] GLYPH_E_N = 7'h06;
    localparam logic [6:0] GLYPH_F_N = 7'h0E;

    // One digit of a display bank; a bank is a packed array of these.
    typedef struct packed {
        logic [3:0] data;
        logic       dp;
        logic       en;
    } digit_t;

endpackage

// File: rtl/seven_segment_scanner_seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph.
module seg7_hex_decode
    import seven_segment_pkg::*;
(
    input  logic [3:0] hexVal,
    output logic [6:0] segN
);

    // Glyph lookup
    always_comb begin
        segN = SEG_BLANK_N;
        case (hexVal)
            4'h0:    segN = GLYPH_0_N;
            4'h1:    segN = GLYPH_1_N;
            4'h2:    segN = GLYPH_2_N;
            4'h3:    segN = GLYPH_3_N;
            4'h4:    segN = GLYPH_4_N;
            4'h5:    segN = GLYPH_5_N;
            4'h6:    segN = GLYPH_6_N;
            4'h7:    segN = GLYPH_7_N;
            4'h8:    segN = GLYPH_8_N;
            4'h9:    segN = GLYPH_9_N;
            4'hA:    segN = GLYPH_A_N;
            4'hB:    segN = GLYPH_B_N;
            4'hC:    segN = GLYPH_C_N;
            4'hD:    segN = GLYPH_D_N;
            4'hE:    segN = GLYPH_E_N;
            4'hF:    segN = GLYPH_F_N;
            default: segN = SEG_BLANK_N;
        endcase
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Double-buffered, time-multiplexed 7-segment scanner with active-low anodes/cathodes.
// Optional feature macro: SEG_DIMMING_EN (adds the brightness port and on-window shortening).
module seven_segment_scanner
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int REFRESH_CYCLES = 100000,
    parameter int BLANK_CYCLES   = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_valid,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    input  logic [NUM_DIGITS-1:0]   wr_dp,
    input  logic [NUM_DIGITS-1:0]   wr_en,
`ifdef SEG_DIMMING_EN
    input  logic [3:0]              brightness,
`endif
    output logic                    update_pending,
    output logic                    frame_start,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n
);

    localparam int TICK_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [TICK_W-1:0] TICK_ZERO = TICK_W'(0);
    localparam logic [TICK_W-1:0] BLANK_T   = TICK_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0]  IDX_ZERO  = IDX_W'(0);

    logic [TICK_W-1:0]             tickCnt_r;
    logic [IDX_W-1:0]              digitIdx_r;
    digit_t [NUM_DIGITS-1:0]       shadowBank_r;
    digit_t [NUM_DIGITS-1:0]       activeBank_r;
    digit_t [NUM_DIGITS-1:0]       wrBank_s;
    logic                          pending_r;
    logic                          frameStart_r;
    logic [6:0]                    segN_r;
    logic                          dpN_r;
    logic [NUM_DIGITS-1:0]         anN_r;
    logic                          tickWrap_s;
    logic                          frameWrap_s;
    digit_t                        curDigit_s;
    logic [6:0]                    glyph_s;
    logic                          inWindow_s;
    logic [NUM_DIGITS-1:0]         anNext_s;

    assign tickWrap_s  = (tickCnt_r == TICK_LAST);
    assign frameWrap_s = tickWrap_s && (digitIdx_r == IDX_LAST);
    assign curDigit_s  = activeBank_r[digitIdx_r];

    // Repack the flat write ports into a digit bank
    always_comb begin
        wrBank_s = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            wrBank_s[i].data = wr_data[4*i +: 4];
            wrBank_s[i].dp   = wr_dp[i];
            wrBank_s[i].en   = wr_en[i];
        end
    end

    seg7_hex_decode uDecode (
        .hexVal (curDigit_s.data),
        .segN   (glyph_s)
    );

`ifdef SEG_DIMMING_EN
    logic [3:0]  bright_r;
    logic [3:0]  brightEff_s;
    logic [31:0] winEnd_s;

    // Hold the brightness level captured at the start of each slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bright_r <= 4'd0;
        end else if (tickCnt_r == TICK_ZERO) begin
            bright_r <= brightness;
        end else begin
            bright_r <= bright_r;
        end
    end

    // Tick 0 sees the live port so the slot uses the value sampled at its own start
    always_comb begin
        brightEff_s = bright_r;
        if (tickCnt_r == TICK_ZERO) begin
            brightEff_s = brightness;
        end else begin
            brightEff_s = bright_r;
        end
        winEnd_s   = 32'(BLANK_CYCLES)
                   + ((32'(REFRESH_CYCLES - BLANK_CYCLES) * (32'(brightEff_s) + 32'd1)) >> 4);
        inWindow_s = (32'(tickCnt_r) >= 32'(BLANK_CYCLES)) && (32'(tickCnt_r) < winEnd_s);
    end
`else
    assign inWindow_s = (tickCnt_r >= BLANK_T);
`endif

    // Anode select: one digit low during its on-window, only if enabled
    always_comb begin
        anNext_s = {NUM_DIGITS{1'b1}};
        if (curDigit_s.en && inWindow_s) begin
            anNext_s[digitIdx_r] = 1'b0;
        end else begin
            anNext_s = {NUM_DIGITS{1'b1}};
        end
    end

    // Slot tick and digit index counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tickCnt_r  <= TICK_ZERO;
            digitIdx_r <= IDX_ZERO;
        end else if (tickWrap_s) begin
            tickCnt_r <= TICK_ZERO;
            if (digitIdx_r == IDX_LAST) begin
                digitIdx_r <= IDX_ZERO;
            end else begin
                digitIdx_r <= digitIdx_r + IDX_ONE;
            end
        end else begin
            tickCnt_r  <= tickCnt_r + TICK_ONE;
            digitIdx_r <= digitIdx_r;
        end
    end

    // Shadow bank capture and pending flag; a write on the wrap cycle stays pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadowBank_r <= '0;
            pending_r    <= 1'b0;
        end else if (wr_valid) begin
            shadowBank_r <= wrBank_s;
            pending_r    <= 1'b1;
        end else if (frameWrap_s) begin
            shadowBank_r <= shadowBank_r;
            pending_r    <= 1'b0;
        end else begin
            shadowBank_r <= shadowBank_r;
            pending_r    <= pending_r;
        end
    end

    // Promotion only at the frame boundary keeps a frame tear-free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            activeBank_r <= '0;
        end else if (frameWrap_s && pending_r) begin
            activeBank_r <= shadowBank_r;
        end else begin
            activeBank_r <= activeBank_r;
        end
    end

    // Output registers, one cycle behind (idx, tick)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frameStart_r <= 1'b0;
            segN_r       <= SEG_BLANK_N;
            dpN_r        <= 1'b1;
            anN_r        <= {NUM_DIGITS{1'b1}};
        end else begin
            frameStart_r <= (digitIdx_r == IDX_ZERO) && (tickCnt_r == TICK_ZERO);
            anN_r        <= anNext_s;
            if (curDigit_s.en) begin
                segN_r <= glyph_s;
                dpN_r  <= ~curDigit_s.dp;
            end else begin
                segN_r <= SEG_BLANK_N;
                dpN_r  <= 1'b1;
            end
        end
    end

    assign update_pending = pending_r;
    assign frame_start    = frameStart_r;
    assign seg_n          = segN_r;
    assign dp_n           = dpN_r;
    assign an_n           = anN_r;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench for seven_segment_scanner (4 digits, 8-cycle slots, 2-cycle blank).
// Define SEG_DIMMING_EN to also exercise the brightness window.
module tb_seven_segment_scanner;

    localparam int ND = 4;
    localparam int RC = 8;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_data = 16'h0000;
    logic [3:0]  wr_dp = 4'h0;
    logic [3:0]  wr_en = 4'h0;
`ifdef SEG_DIMMING_EN
    logic [3:0]  brightness = 4'd15;
`endif
    logic        update_pending;
    logic        frame_start;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;

    always #5 clk = ~clk;

    seven_segment_scanner #(
        .NUM_DIGITS     (ND),
        .REFRESH_CYCLES (RC),
        .BLANK_CYCLES   (BC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_valid       (wr_valid),
        .wr_data        (wr_data),
        .wr_dp          (wr_dp),
        .wr_en          (wr_en),
`ifdef SEG_DIMMING_EN
        .brightness     (brightness),
`endif
        .update_pending (update_pending),
        .frame_start    (frame_start),
        .seg_n          (seg_n),
        .dp_n           (dp_n),
        .an_n           (an_n)
    );

    int          numCompared = 0;
    int          numMismatched = 0;
    logic [13:0] sbQ[$];

    // Reference display state
    int          mTick;
    int          mIdx;
    logic [15:0] mShData, mAcData;
    logic [3:0]  mShDp, mAcDp, mShEn, mAcEn;
    logic        mPend;
    logic [3:0]  mBright;

    // Conventional active-high gfedcba glyphs, inverted for the active-low bus
    function automatic logic [6:0] refGlyph(input logic [3:0] h);
        logic [6:0] v;
        case (h)
            4'h0: v = 7'h3F;  4'h1: v = 7'h06;  4'h2: v = 7'h5B;  4'h3: v = 7'h4F;
            4'h4: v = 7'h66;  4'h5: v = 7'h6D;  4'h6: v = 7'h7D;  4'h7: v = 7'h07;
            4'h8: v = 7'h7F;  4'h9: v = 7'h6F;  4'hA: v = 7'h77;  4'hB: v = 7'h7C;
            4'hC: v = 7'h39;  4'hD: v = 7'h5E;  4'hE: v = 7'h79;  default: v = 7'h71;
        endcase
        return ~v;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numCompared++;
        if (got !== exp) begin
            numMismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mTick = 0; mIdx = 0; mPend = 1'b0; mBright = 4'd0;
        mShData = 16'h0; mAcData = 16'h0;
        mShDp = 4'h0; mAcDp = 4'h0; mShEn = 4'h0; mAcEn = 4'h0;
    endtask

    // Push the expected output for the coming edge, advance the model, then pop and compare
    task automatic step(input string tag);
        logic [13:0] e;
        logic [3:0]  an;
        logic [3:0]  br;
        logic [3:0]  nib;
        int          winEnd;
        if (!rst_n) begin
            modelReset();
            e = {1'b0, 1'b0, 1'b1, 7'h7F, 4'hF};
        end else begin
            nib = mAcData[4*mIdx +: 4];
            br  = 4'd15;
`ifdef SEG_DIMMING_EN
            br = (mTick == 0) ? brightness : mBright;
            if (mTick == 0) mBright = brightness;
`endif
            winEnd = BC + ((RC - BC) * (int'(br) + 1)) / 16;
            an = 4'hF;
            if (mAcEn[mIdx] && mTick >= BC && mTick < winEnd) an[mIdx] = 1'b0;
            e[13]   = (mIdx == 0) && (mTick == 0);
            e[11]   = mAcEn[mIdx] ? ~mAcDp[mIdx] : 1'b1;
            e[10:4] = mAcEn[mIdx] ? refGlyph(nib) : 7'h7F;
            e[3:0]  = an;
            if (mTick == RC - 1) begin
                mTick = 0;
                if (mIdx == ND - 1) begin
                    mIdx = 0;
                    if (mPend) begin
                        mAcData = mShData; mAcDp = mShDp; mAcEn = mShEn; mPend = 1'b0;
                    end
                end else begin
                    mIdx++;
                end
            end else begin
                mTick++;
            end
            if (wr_valid) begin
                mShData = wr_data; mShDp = wr_dp; mShEn = wr_en; mPend = 1'b1;
            end
            e[12] = mPend;
        end
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        checkVal(tag, 32'({frame_start, update_pending, dp_n, seg_n, an_n}), 32'(sbQ.pop_front()));
    endtask

    task automatic doWrite(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
        wr_data = d; wr_dp = dp; wr_en = en; wr_valid = 1'b1;
        step("write");
        wr_valid = 1'b0;
    endtask

    // Step until a new frame_start appears; an expired budget counts as a failure
    task automatic waitFrame(input string tag);
        for (int i = 0; i < 80; i++) begin
            step(tag);
            if (frame_start) return;
        end
        checkVal({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Observe one whole frame starting at the next frame_start
    task automatic runFrame(input string tag, input logic [6:0] glyph, input bit doOrder,
                            output int lowCnt, output int hitCnt, output int blank2Cnt);
        logic [3:0] expAn;
        lowCnt = 0; hitCnt = 0; blank2Cnt = 0;
        waitFrame(tag);
        for (int k = 0; k < ND * RC; k++) begin
            if (k > 0) step(tag);
            if (an_n != 4'hF) lowCnt++;
            if (an_n != 4'hF && seg_n == glyph) hitCnt++;
            if (k / RC == 2 && an_n == 4'hF && seg_n == 7'h7F) blank2Cnt++;
            if (doOrder && (k % RC) == 4) begin
                expAn = ~(4'b0001 << (k / RC));
                checkVal("scan_order", 32'(an_n), 32'(expAn));
            end
        end
    endtask

    initial begin
        int low, hit, blk;
        modelReset();

        // Reset held with clocks and a write request present
        wr_valid = 1'b1; wr_data = 16'hFFFF; wr_en = 4'hF;
        for (int i = 0; i < 6; i++) step("reset");
        wr_valid = 1'b0;
        rst_n = 1'b1;

        // Full write; shown from the next frame, digit 2 carries the dp
        doWrite(16'h3210, 4'b0100, 4'hF);
        checkVal("pending_set", 32'(update_pending), 32'd1);
        runFrame("frame_3210", 7'h24, 1'b1, low, hit, blk);
        checkVal("on_cycles", 32'(low), 32'd24);
        checkVal("digit2_glyph_cycles", 32'(hit), 32'd6);
        checkVal("pending_clear", 32'(update_pending), 32'd0);

        // Digit 2 disabled: bus fully blank for its slot
        doWrite(16'h3210, 4'b0100, 4'b1011);
        runFrame("frame_en1011", 7'h24, 1'b0, low, hit, blk);
        checkVal("digit2_blank_cycles", 32'(blk), 32'd8);
        checkVal("on_cycles_3dig", 32'(low), 32'd18);

        // Back-to-back writes mid-frame: last one wins
        for (int i = 0; i < 5; i++) step("mid");
        doWrite(16'hAAAA, 4'h0, 4'hF);
        doWrite(16'hBBBB, 4'h0, 4'hF);
        runFrame("frame_b", 7'h03, 1'b0, low, hit, blk);
        checkVal("b_cycles", 32'(hit), 32'd24);

        // Write landing exactly on the wrap cycle is held one frame
        for (int i = 0; i < 64 && !(mIdx == ND - 1 && mTick == RC - 1); i++) step("sync");
        checkVal("sync_wrap", 32'(mIdx * RC + mTick), 32'(ND * RC - 1));
        doWrite(16'hCCCC, 4'h0, 4'hF);
        runFrame("frame_old", 7'h46, 1'b0, low, hit, blk);
        checkVal("c_not_yet", 32'(hit), 32'd0);
        runFrame("frame_c", 7'h46, 1'b0, low, hit, blk);
        checkVal("c_cycles", 32'(hit), 32'd24);

`ifdef SEG_DIMMING_EN
        brightness = 4'd7;
        runFrame("dim7", 7'h46, 1'b0, low, hit, blk);
        checkVal("dim7_on_cycles", 32'(low), 32'd12);
        brightness = 4'd15;
        runFrame("dim15", 7'h46, 1'b0, low, hit, blk);
        checkVal("dim15_on_cycles", 32'(low), 32'd24);
`endif

        // Reset mid-frame with a write in flight
        for (int i = 0; i < 3; i++) step("pre_rst");
        wr_valid = 1'b1; wr_data = 16'h5555; wr_en = 4'hF;
        rst_n = 1'b0;
        #1;
        checkVal("async_rst", 32'({update_pending, dp_n, seg_n, an_n}), 32'({1'b0, 1'b1, 7'h7F, 4'hF}));
        step("in_rst");
        wr_valid = 1'b0;
        step("in_rst");
        rst_n = 1'b1;
        runFrame("post_rst", 7'h12, 1'b0, low, hit, blk);
        checkVal("post_rst_dark", 32'(low), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
